// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, mux-select encodings and defaults for the multi-cycle control.  Rev 1.0
`default_nettype none
package ctrl_pkg;

   localparam int MEM_TIMEOUT_DEFAULT = 255;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } ctrl_state_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_BRIMM = 2'd1,
      PC_JALR  = 2'd2
   } pc_sel_t;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_t;

endpackage
`default_nettype wire

// File: rtl/fe_pkg.sv
// fe_pkg: front-end decoder types shared with the control path.  Rev 1.0
`default_nettype none
package fe_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } RV32I_OPCODE_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_mem_watchdog.sv
// ctrl_mem_watchdog: wait-cycle counter for an outstanding memory request.  Rev 1.0
`default_nettype none
module ctrl_mem_watchdog #(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);

   logic [TO_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en)
         count_d = count_q + TO_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // Fires in the cycle whose increment would reach the limit.
   assign expired = en && (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with halt and retire count.  Rev 1.0
`default_nettype none
module rv32i_multicycle_ctrl
   import ctrl_pkg::*;
   import fe_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int TO_W        = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             alu_b_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             halt,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   ctrl_state_t      state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   logic    w_imem_req, w_ir_we, w_pc_we, w_alu_b_sel;
   logic    w_dmem_req, w_dmem_we, w_rf_we;
   pc_sel_t w_pc_sel;
   wb_sel_t w_wb_sel;

   logic w_wd_ack, w_wd_en, w_wd_clr, w_wd_expired;

   assign w_wd_ack = (state_q == S_FETCH) ? imem_ack : dmem_ack;
   assign w_wd_en  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !w_wd_ack;
   // MEM can hand straight back to FETCH, so clear on any state change.
   assign w_wd_clr = (state_d != state_q);

   ctrl_mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_wd_clr),
      .en      (w_wd_en),
      .expired (w_wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      instret_d   = instret_q;
      illegal_d   = illegal_q;
      bus_err_d   = bus_err_q;
      w_imem_req  = 1'b0;
      w_ir_we     = 1'b0;
      w_pc_we     = 1'b0;
      w_pc_sel    = PC_PLUS4;
      w_alu_b_sel = 1'b0;
      w_dmem_req  = 1'b0;
      w_dmem_we   = 1'b0;
      w_rf_we     = 1'b0;
      w_wb_sel    = WB_ALU;
      case (state_q)
         S_FETCH: begin
            w_imem_req = 1'b1;
            if (imem_ack) begin
               w_ir_we = 1'b1;
               state_d = S_DECODE;
            end else if (w_wd_expired) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_SYSTEM: begin
                  instret_d = instret_q + CNT_W'(1);
                  state_d   = S_HALT;
               end
               OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
               OP_LUI, OP_BRANCH, OP_JALR, OP_JAL:
                  state_d = S_EXEC;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC: w_alu_b_sel = 1'b1;
               default:                                      w_alu_b_sel = 1'b0;
            endcase
            case (opcode)
               OP_BRANCH: begin
                  w_pc_we   = 1'b1;
                  w_pc_sel  = branch_taken ? PC_BRIMM : PC_PLUS4;
                  instret_d = instret_q + CNT_W'(1);
                  state_d   = S_FETCH;
               end
               OP_LOAD, OP_STORE: state_d = S_MEM;
               default:           state_d = S_WB;
            endcase
         end
         S_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (opcode == OP_STORE);
            if (dmem_ack) begin
               if (opcode == OP_STORE) begin
                  w_pc_we   = 1'b1;
                  instret_d = instret_q + CNT_W'(1);
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (w_wd_expired) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            w_rf_we   = 1'b1;
            w_pc_we   = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
            case (opcode)
               OP_LOAD: w_wb_sel = WB_LOAD;
               OP_JAL:  begin w_wb_sel = WB_PC4; w_pc_sel = PC_BRIMM; end
               OP_JALR: begin w_wb_sel = WB_PC4; w_pc_sel = PC_JALR;  end
               OP_LUI:  w_wb_sel = WB_IMM;
               default: w_wb_sel = WB_ALU;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Every strobe is forced low while reset is held, whatever the state.
   assign imem_req  = rst_n & w_imem_req;
   assign ir_we     = rst_n & w_ir_we;
   assign pc_we     = rst_n & w_pc_we;
   assign pc_sel    = rst_n ? 2'(w_pc_sel) : 2'b00;
   assign alu_b_sel = rst_n & w_alu_b_sel;
   assign dmem_req  = rst_n & w_dmem_req;
   assign dmem_we   = rst_n & w_dmem_we;
   assign rf_we     = rst_n & w_rf_we;
   assign wb_sel    = rst_n ? 2'(w_wb_sel) : 2'b00;
   assign halt      = rst_n & (state_q == S_HALT);
   assign illegal   = rst_n & illegal_q;
   assign bus_err   = rst_n & bus_err_q;
   assign instret   = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb_rv32i_multicycle_ctrl: directed checks of the control FSM with MEM_TIMEOUT=4.  Rev 1.0
`default_nettype none
module tb_rv32i_multicycle_ctrl;

   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] ENV  = 7'b1110011;
   localparam logic [6:0] BAD  = 7'b0000000;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        branch_taken, imem_ack, dmem_ack;
   logic        imem_req, ir_we, pc_we, alu_b_sel, dmem_req, dmem_we, rf_we;
   logic [1:0]  pc_sel, wb_sel;
   logic        halt, illegal, bus_err;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   rv32i_multicycle_ctrl #(
      .MEM_TIMEOUT (4),
      .TO_W        (8),
      .CNT_W       (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .imem_ack     (imem_ack),
      .dmem_ack     (dmem_ack),
      .imem_req     (imem_req),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .alu_b_sel    (alu_b_sel),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .halt         (halt),
      .illegal      (illegal),
      .bus_err      (bus_err),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs after the falling edge, then settle before checks.
   task automatic cyc(input logic r, input logic ia, input logic da,
                      input logic [6:0] op, input logic bt);
      @(negedge clk);
      rst_n        = r;
      imem_ack     = ia;
      dmem_ack     = da;
      opcode       = op;
      branch_taken = bt;
      #1;
   endtask

   task automatic eo(input string tag,
                     input logic ireq, input logic irwe, input logic pcwe,
                     input logic [1:0] psel, input logic alub, input logic dreq,
                     input logic dwe, input logic rfwe, input logic [1:0] wsel,
                     input logic hlt, input logic ill, input logic berr);
      logic [13:0] obs;
      logic [13:0] exp;
      obs = {imem_req, ir_we, pc_we, pc_sel, alu_b_sel, dmem_req, dmem_we,
             rf_we, wb_sel, halt, illegal, bus_err};
      exp = {ireq, irwe, pcwe, psel, alub, dreq, dwe, rfwe, wsel, hlt, ill, berr};
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic ci(input string tag, input logic [31:0] exp);
      checks++;
      assert (instret === exp)
      else begin
         errors++;
         $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = BAD; branch_taken = 1'b0;

      cyc(0, 1, 1, ADD, 1); eo("rst_pre", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(0, 0, 0, ADD, 0); eo("rst", 0,0,0,0,0,0,0,0,0,0,0,0);
      ci("rst_cnt", 0);

      // ADD, zero-wait fetch
      cyc(1, 1, 0, ADD, 0); eo("add_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, ADD, 0); eo("add_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, ADD, 0); eo("add_E", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, ADD, 0); eo("add_W", 0,0,1,0,0,0,0,1,0,0,0,0);
      ci("add_cnt_W", 0);

      // LW with dmem_ack on the 4th MEM cycle (same cycle as the watchdog limit)
      cyc(1, 1, 0, LW, 0); eo("lw_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      ci("add_cnt", 1);
      cyc(1, 0, 0, LW, 0); eo("lw_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LW, 0); eo("lw_E", 0,0,0,0,1,0,0,0,0,0,0,0);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0, LW, 0); eo("lw_M_wait", 0,0,0,0,0,1,0,0,0,0,0,0);
      end
      cyc(1, 0, 1, LW, 0); eo("lw_M_ack", 0,0,0,0,0,1,0,0,0,0,0,0);
      cyc(1, 0, 0, LW, 0); eo("lw_W", 0,0,1,0,0,0,0,1,1,0,0,0);

      // BEQ taken then not taken
      cyc(1, 1, 0, BEQ, 0); eo("beq_t_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      ci("lw_cnt", 2);
      cyc(1, 0, 0, BEQ, 1); eo("beq_t_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, BEQ, 1); eo("beq_t_E", 0,0,1,1,0,0,0,0,0,0,0,0);
      cyc(1, 1, 0, BEQ, 0); eo("beq_n_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      ci("beq_t_cnt", 3);
      cyc(1, 0, 0, BEQ, 0); eo("beq_n_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, BEQ, 0); eo("beq_n_E", 0,0,1,0,0,0,0,0,0,0,0,0);

      // JALR
      cyc(1, 1, 0, JALR, 0); eo("jalr_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      ci("beq_n_cnt", 4);
      cyc(1, 0, 0, JALR, 0); eo("jalr_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, JALR, 0); eo("jalr_E", 0,0,0,0,1,0,0,0,0,0,0,0);
      cyc(1, 0, 0, JALR, 0); eo("jalr_W", 0,0,1,2,0,0,0,1,2,0,0,0);

      // SW with zero-wait dmem_ack, no WB cycle
      cyc(1, 1, 0, SW, 0); eo("sw_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      ci("jalr_cnt", 5);
      cyc(1, 0, 0, SW, 0); eo("sw_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, SW, 0); eo("sw_E", 0,0,0,0,1,0,0,0,0,0,0,0);
      cyc(1, 0, 1, SW, 0); eo("sw_M", 0,0,1,0,0,1,1,0,0,0,0,0);

      // LUI: imem_ack on 4th FETCH cycle wins over the limit; stray dmem_ack ignored
      cyc(1, 0, 1, LUI, 0); eo("lui_F_w1", 1,0,0,0,0,0,0,0,0,0,0,0);
      ci("sw_cnt", 6);
      cyc(1, 0, 1, LUI, 0); eo("lui_F_w2", 1,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 1, LUI, 0); eo("lui_F_w3", 1,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 1, 0, LUI, 0); eo("lui_F_ack", 1,1,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LUI, 0); eo("lui_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LUI, 0); eo("lui_E", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LUI, 0); eo("lui_W", 0,0,1,0,0,0,0,1,3,0,0,0);

      // Fetch timeout: 4 FETCH cycles without ack
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0, 0, LUI, 0); eo("to_F", 1,0,0,0,0,0,0,0,0,0,0,0);
      end
      ci("lui_cnt", 7);
      cyc(1, 0, 0, LUI, 0); eo("to_halt", 0,0,0,0,0,0,0,0,0,1,0,1);
      cyc(1, 1, 1, LUI, 0); eo("halt_stays", 0,0,0,0,0,0,0,0,0,1,0,1);
      ci("halt_cnt", 7);

      // Reset out of HALT, then illegal opcode
      cyc(0, 1, 1, LUI, 0); eo("rst_halt", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 1, 0, BAD, 0); eo("ill_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      ci("rst_cnt2", 0);
      cyc(1, 0, 0, BAD, 0); eo("ill_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, BAD, 0); eo("ill_halt", 0,0,0,0,0,0,0,0,0,1,1,0);
      ci("ill_cnt", 0);

      // EBREAK/ECALL retires and halts without illegal
      cyc(0, 0, 0, ENV, 0); eo("rst_ill", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 1, 0, ENV, 0); eo("env_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, ENV, 0); eo("env_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, ENV, 0); eo("env_halt", 0,0,0,0,0,0,0,0,0,1,0,0);
      ci("env_cnt", 1);

      // Reset for one edge in the middle of a MEM handshake
      cyc(0, 0, 0, LW, 0); eo("rst_env", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 1, 0, LW, 0); eo("mr_F", 1,1,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LW, 0); eo("mr_D", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LW, 0); eo("mr_E", 0,0,0,0,1,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LW, 0); eo("mr_M", 0,0,0,0,0,1,0,0,0,0,0,0);
      cyc(0, 0, 1, LW, 0); eo("mr_rst", 0,0,0,0,0,0,0,0,0,0,0,0);
      cyc(1, 0, 0, LW, 0); eo("mr_after_F", 1,0,0,0,0,0,0,0,0,0,0,0);
      ci("mr_cnt", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
